hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 155 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for a five-stage core.
// It drives the stage-register enables and flushes, the PC redirect select and
// the fetch enable, tracks data-memory waits and halt, and keeps two
// saturating performance counters (stall cycles and redirect flushes).
module hazard_ctrl (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        dREN_mem,
  input  logic        dWEN_mem,
  input  logic        dREN_ex,
  input  logic [4:0]  wsel_ex,
  input  logic [4:0]  rs_id,
  input  logic [4:0]  rt_id,
  input  logic        redirect_mem,
  input  logic        halt_mem,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic        pc_sel,
  output logic        iREN,
  output logic        halt,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  logic w_mem_req;
  logic w_load_use;
  logic w_stall_tick;
  logic w_flush_tick;

  // A load in EX whose destination (never r0) feeds the instruction in ID.
  assign w_mem_req  = dREN_mem | dWEN_mem;
  assign w_load_use = dREN_ex && (wsel_ex != 5'd0) &&
                      ((wsel_ex == rs_id) || (wsel_ex == rt_id));

  // Decode state and hazards into enables, flushes and the next state.
  // NOTE: every output gets a default first so no path leaves one unassigned
  // (an unassigned path would infer a latch).
  always_comb begin
    pc_en        = 1'b0;
    ifid_en      = 1'b0;
    idex_en      = 1'b0;
    exmem_en     = 1'b0;
    memwb_en     = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_flush  = 1'b0;
    pc_sel       = 1'b0;
    iREN         = 1'b0;
    halt         = 1'b0;
    w_next_state = r_state;
    if (!RST) begin
      case (r_state)
        HALTED: begin
          halt = 1'b1;
        end
        default: begin
          iREN = 1'b1;
          if (w_mem_req && !dhit) begin
            // Data memory busy: freeze the whole pipe until dhit.
            w_next_state = DWAIT;
          end else begin
            w_next_state = RUN;
            if (halt_mem) begin
              // Retire the halt, squash everything younger, stop fetch.
              ifid_en      = 1'b1;
              idex_en      = 1'b1;
              exmem_en     = 1'b1;
              memwb_en     = 1'b1;
              ifid_flush   = 1'b1;
              idex_flush   = 1'b1;
              exmem_flush  = 1'b1;
              w_next_state = HALTED;
            end else if (redirect_mem) begin
              // Taken control transfer: load the target even on an ifetch miss.
              pc_en        = 1'b1;
              pc_sel       = 1'b1;
              ifid_en      = 1'b1;
              idex_en      = 1'b1;
              exmem_en     = 1'b1;
              memwb_en     = 1'b1;
              ifid_flush   = 1'b1;
              idex_flush   = 1'b1;
              exmem_flush  = 1'b1;
            end else if (w_load_use) begin
              // Hold PC and IF/ID, send a bubble into EX.
              idex_en      = 1'b1;
              idex_flush   = 1'b1;
              exmem_en     = 1'b1;
              memwb_en     = 1'b1;
            end else if (!ihit) begin
              // Fetch not ready: hold PC, send a bubble into ID.
              ifid_en      = 1'b1;
              ifid_flush   = 1'b1;
              idex_en      = 1'b1;
              exmem_en     = 1'b1;
              memwb_en     = 1'b1;
            end else begin
              pc_en        = 1'b1;
              ifid_en      = 1'b1;
              idex_en      = 1'b1;
              exmem_en     = 1'b1;
              memwb_en     = 1'b1;
            end
          end
        end
      endcase
    end
  end

  // iREN is high exactly in RUN/DWAIT outside reset, so a stall is a held PC there.
  assign w_stall_tick = iREN & ~pc_en;
  assign w_flush_tick = pc_sel;

  // Register the state and the saturating performance counters.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= RUN;
      r_stall_cnt <= 16'h0000;
      r_flush_cnt <= 16'h0000;
    end else begin
      r_state <= w_next_state;
      if (w_stall_tick && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'h0001;
      end
      if (w_flush_tick && (r_flush_cnt != 16'hFFFF)) begin
        r_flush_cnt <= r_flush_cnt + 16'h0001;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed bench for hazard_ctrl with a behavioural model.
// Control outputs are packed {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
// ifid_flush, idex_flush, exmem_flush, pc_sel, iREN, halt}.
module tb_hazard_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ihit, dhit, dREN_mem, dWEN_mem, dREN_ex;
  logic [4:0]  wsel_ex, rs_id, rt_id;
  logic        redirect_mem, halt_mem;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_flush, exmem_flush, pc_sel, iREN, halt;
  logic [15:0] stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_errors = 0;

  hazard_ctrl dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .dREN_mem(dREN_mem), .dWEN_mem(dWEN_mem), .dREN_ex(dREN_ex),
    .wsel_ex(wsel_ex), .rs_id(rs_id), .rt_id(rt_id),
    .redirect_mem(redirect_mem), .halt_mem(halt_mem),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .pc_sel(pc_sel), .iREN(iREN), .halt(halt),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 CLK = ~CLK;

  // Expected control vectors, one per rule.
  localparam logic [10:0] C_ZERO    = 11'b00000_000_000;
  localparam logic [10:0] C_HALTED  = 11'b00000_000_001;
  localparam logic [10:0] C_MEMSTL  = 11'b00000_000_010;
  localparam logic [10:0] C_HALTING = 11'b01111_111_010;
  localparam logic [10:0] C_REDIR   = 11'b11111_111_110;
  localparam logic [10:0] C_LDUSE   = 11'b00111_010_010;
  localparam logic [10:0] C_IMISS   = 11'b01111_100_010;
  localparam logic [10:0] C_RUN     = 11'b11111_000_010;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: priority rules applied to the current inputs; only "halted" is state.
  function automatic logic [10:0] model_ctrl(
    input logic rst, input logic halted, input logic i_hit, input logic d_hit,
    input logic mem_r, input logic mem_w, input logic ex_r, input logic [4:0] ws,
    input logic [4:0] rs, input logic [4:0] rt, input logic redir, input logic hlt);
    logic lu;
    lu = ex_r && (ws != 0) && (ws == rs || ws == rt);
    if (rst)                     return C_ZERO;
    if (halted)                  return C_HALTED;
    if ((mem_r || mem_w) && !d_hit) return C_MEMSTL;
    if (hlt)                     return C_HALTING;
    if (redir)                   return C_REDIR;
    if (lu)                      return C_LDUSE;
    if (!i_hit)                  return C_IMISS;
    return C_RUN;
  endfunction

  function automatic int sat_inc(input int v);
    return (v < 65535) ? v + 1 : 65535;
  endfunction

  logic        m_halted;
  int          m_stall, m_flush;
  logic [10:0] m_ctrl, dut_ctrl;
  logic        sat_load = 1'b0;

  always_comb m_ctrl = model_ctrl(RST, m_halted, ihit, dhit, dREN_mem, dWEN_mem,
                                  dREN_ex, wsel_ex, rs_id, rt_id, redirect_mem, halt_mem);
  assign dut_ctrl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                     ifid_flush, idex_flush, exmem_flush, pc_sel, iREN, halt};

  // Model state: halt latch and saturating counters.
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_halted <= 1'b0;
      m_stall  <= 0;
      m_flush  <= 0;
    end else if (!m_halted) begin
      if (m_ctrl[10] == 1'b0)
        m_stall <= sat_inc(sat_load ? 32'hFFFE : m_stall);
      else if (sat_load)
        m_stall <= 32'hFFFE;
      if (m_ctrl[2]) m_flush <= sat_inc(m_flush);
      if (m_ctrl == C_HALTING) m_halted <= 1'b1;
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge CLK) begin
    check("ctrl", {21'd0, dut_ctrl}, {21'd0, m_ctrl});
    if (!sat_load) begin
      check("stall_cnt", {16'd0, stall_cnt}, m_stall);
      check("flush_cnt", {16'd0, flush_cnt}, m_flush);
    end
  end

  task automatic next();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1; ihit = 0; dhit = 0; dREN_mem = 0; dWEN_mem = 0; dREN_ex = 0;
    wsel_ex = 0; rs_id = 0; rt_id = 0; redirect_mem = 0; halt_mem = 0;
    repeat (2) @(negedge CLK);
    check("rst_ctrl_zero", {21'd0, dut_ctrl}, 32'd0);
    next();
    RST = 1'b0; ihit = 1'b1;

    // Clean run for 10 cycles.
    repeat (10) next();
    @(negedge CLK);
    check("run_ctrl", {21'd0, dut_ctrl}, {21'd0, C_RUN});
    check("run_stall0", {16'd0, stall_cnt}, 32'd0);
    check("run_flush0", {16'd0, flush_cnt}, 32'd0);
    next();

    // Data-memory wait: 3 miss cycles then dhit.
    dREN_mem = 1'b1; dhit = 1'b0;
    @(negedge CLK);
    check("dwait_pc_en", {31'd0, pc_en}, 32'd0);
    check("dwait_memwb_en", {31'd0, memwb_en}, 32'd0);
    repeat (2) next();
    @(negedge CLK);
    check("dwait3_ifid_en", {31'd0, ifid_en}, 32'd0);
    next();
    dhit = 1'b1;
    @(negedge CLK);
    check("dhit_ctrl", {21'd0, dut_ctrl}, {21'd0, C_RUN});
    check("dhit_stall3", {16'd0, stall_cnt}, 32'd3);
    next();
    dREN_mem = 1'b0; dhit = 1'b0;
    @(negedge CLK);
    check("after_dhit_pc_en", {31'd0, pc_en}, 32'd1);
    next();

    // Load-use via rs, then via rt, then wsel_ex = 0 (no hazard).
    dREN_ex = 1'b1; wsel_ex = 5'd5; rs_id = 5'd5; rt_id = 5'd7;
    @(negedge CLK);
    check("lu_pc_en", {31'd0, pc_en}, 32'd0);
    check("lu_ifid_en", {31'd0, ifid_en}, 32'd0);
    check("lu_idex_flush", {31'd0, idex_flush}, 32'd1);
    next();
    rs_id = 5'd1; rt_id = 5'd5;
    next();
    wsel_ex = 5'd0; rs_id = 5'd0; rt_id = 5'd0;
    @(negedge CLK);
    check("lu_r0_pc_en", {31'd0, pc_en}, 32'd1);
    next();

    // Redirect together with load-use and an ifetch miss.
    wsel_ex = 5'd5; rs_id = 5'd5; redirect_mem = 1'b1; ihit = 1'b0;
    @(negedge CLK);
    check("redir_ctrl", {21'd0, dut_ctrl}, {21'd0, C_REDIR});
    next();
    redirect_mem = 1'b0; dREN_ex = 1'b0; ihit = 1'b1;
    @(negedge CLK);
    check("redir_flush1", {16'd0, flush_cnt}, 32'd1);
    check("redir_stall5", {16'd0, stall_cnt}, 32'd5);
    next();

    // Plain ifetch miss.
    ihit = 1'b0;
    @(negedge CLK);
    check("imiss_ctrl", {21'd0, dut_ctrl}, {21'd0, C_IMISS});
    next();
    ihit = 1'b1;

    // Reset while in DWAIT returns to RUN with nothing pending.
    dREN_mem = 1'b1;
    next();
    RST = 1'b1;
    @(negedge CLK);
    check("rst_dwait_ctrl", {21'd0, dut_ctrl}, 32'd0);
    check("rst_dwait_stall", {16'd0, stall_cnt}, 32'd0);
    dREN_mem = 1'b0;
    next();
    RST = 1'b0;
    @(negedge CLK);
    check("post_rst_pc_en", {31'd0, pc_en}, 32'd1);
    next();

    // Halt together with redirect: halt wins, then held for 20 cycles.
    halt_mem = 1'b1; redirect_mem = 1'b1;
    @(negedge CLK);
    check("halt_pc_sel", {31'd0, pc_sel}, 32'd0);
    check("halt_ctrl", {21'd0, dut_ctrl}, {21'd0, C_HALTING});
    next();
    halt_mem = 1'b0; redirect_mem = 1'b0;
    for (int i = 0; i < 20; i++) begin
      ihit = i[0]; dREN_mem = i[1]; redirect_mem = i[2];
      @(negedge CLK);
      next();
    end
    @(negedge CLK);
    check("halted_halt", {31'd0, halt}, 32'd1);
    check("halted_iren", {31'd0, iREN}, 32'd0);
    check("halted_stall1", {16'd0, stall_cnt}, 32'd1);
    check("halted_flush0", {16'd0, flush_cnt}, 32'd0);
    next();
    ihit = 1'b1; dREN_mem = 1'b0; redirect_mem = 1'b0;
    RST = 1'b1;
    next();
    RST = 1'b0;
    @(negedge CLK);
    check("unhalt_ctrl", {21'd0, dut_ctrl}, {21'd0, C_RUN});
    check("unhalt_stall0", {16'd0, stall_cnt}, 32'd0);
    next();

    // Saturation: preload stall counter to FFFE, then 3 miss cycles.
    ihit = 1'b0; sat_load = 1'b1;
    force dut.r_stall_cnt = 16'hFFFE;
    #1;
    release dut.r_stall_cnt;
    check("sat_preload", {16'd0, stall_cnt}, 32'h0000FFFE);
    next();
    sat_load = 1'b0;
    repeat (2) next();
    @(negedge CLK);
    check("sat_ffff", {16'd0, stall_cnt}, 32'h0000FFFF);
    next();
    ihit = 1'b1;
    repeat (2) next();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
